// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU operation arbiter.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned FLAG_W = 5;
  localparam int unsigned RM_W   = 3;

  localparam logic [31:0]       CANON_NAN = 32'h7FC0_0000;
  localparam logic [FLAG_W-1:0] FFLAG_NV  = 5'b10000;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr_i, wrapping.
module fpu_rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDXW  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDXW-1:0]  rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDXW-1:0]  grant_idx_o,
  output logic             grant_valid_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx           = 0;
    found         = 1'b0;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(rr_ptr_i) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDXW'(idx);
      end
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/fpu_op_arbiter.sv
// Shares one multi-cycle FPU between N_REQ requesters, one op in flight, round-robin grant.
// Define FPU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that answers with a qNaN/NV error.
module fpu_op_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned OPW            = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OPW-1:0]    req_op,
  input  logic [N_REQ*32-1:0]     req_a,
  input  logic [N_REQ*32-1:0]     req_b,
  input  logic [N_REQ*32-1:0]     req_c,
  input  logic [N_REQ*RM_W-1:0]   req_rm,
  output logic                    fpu_start,
  output logic [OPW-1:0]          fpu_op,
  output logic [31:0]             fpu_a,
  output logic [31:0]             fpu_b,
  output logic [31:0]             fpu_c,
  output logic [RM_W-1:0]         fpu_rm,
  input  logic                    fpu_done,
  input  logic [31:0]             fpu_result,
  input  logic [FLAG_W-1:0]       fpu_fflags,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [31:0]             resp_data,
  output logic [FLAG_W-1:0]       resp_fflags,
  output logic                    resp_err,
  output logic                    arb_busy
);

  localparam int unsigned IDXW = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d;
  logic [RM_W-1:0]   rm_q, rm_d;
  logic [31:0]       data_q, data_d;
  logic [FLAG_W-1:0] fflags_q, fflags_d;

  logic [N_REQ-1:0]  gnt_onehot;
  logic [IDXW-1:0]   gnt_idx;
  logic              gnt_valid;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  fpu_rr_arbiter #(
    .N_REQ(N_REQ),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .valid_i      (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (gnt_onehot),
    .grant_idx_o  (gnt_idx),
    .grant_valid_o(gnt_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    rm_d       = rm_q;
    data_d     = data_q;
    fflags_d   = fflags_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    req_ready  = '0;
    fpu_start  = 1'b0;
    resp_valid = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          req_ready = gnt_onehot;
          owner_d   = gnt_idx;
          op_d      = req_op[gnt_idx*OPW +: OPW];
          a_d       = req_a[gnt_idx*32 +: 32];
          b_d       = req_b[gnt_idx*32 +: 32];
          c_d       = req_c[gnt_idx*32 +: 32];
          rm_d      = req_rm[gnt_idx*RM_W +: RM_W];
          state_d   = StIssue;
        end
      end
      StIssue: begin
        fpu_start = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = StWait;
      end
      StWait: begin
        // A done coinciding with watchdog expiry takes priority.
        if (fpu_done) begin
          data_d   = fpu_result;
          fflags_d = fpu_fflags;
`ifdef FPU_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = StResp;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d   = CANON_NAN;
          fflags_d = FFLAG_NV;
          err_d    = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          // Fairness advances only once an operation has been fully returned.
          rr_ptr_d = (owner_q == IDXW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      rm_q     <= '0;
      data_q   <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      rm_q     <= rm_d;
      data_q   <= data_d;
      fflags_q <= fflags_d;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  // Watchdog compiled out; the limit parameter is kept so instantiations stay identical.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign resp_err       = 1'b0;
`endif

  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_c       = c_q;
  assign fpu_rm      = rm_q;
  assign resp_data   = data_q;
  assign resp_fflags = fflags_q;
  assign arb_busy    = (state_q != StIdle);

endmodule
